// File: rtl/sd_stream_pkg.sv
// Shared constants and types for the SD sector streamer: sector geometry,
// write-side FSM states and the ping-pong bank index.
package sd_stream_pkg;
  localparam int unsigned SECTOR_BYTES = 512;
  localparam int unsigned ADDR_W       = 9;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ISSUE,
    W_WAIT,
    W_DRAIN
  } wstate_t;

  typedef logic bank_t;
endpackage

// File: rtl/sd_sector_dpram.sv
// Two-bank sector buffer: one synchronous write port, one synchronous read
// port with 1-cycle latency. Array contents are not reset.
module sd_sector_dpram
  import sd_stream_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W:0]   waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W:0]   raddr,
  output logic [7:0]        rdata
);
  logic [7:0] mem [0:2*SECTOR_BYTES-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/sd_sector_streamer.sv
// Fetches a run of sectors from the SD host into a ping-pong buffer and
// replays each loaded sector as a valid/ready byte stream.
module sd_sector_streamer
  import sd_stream_pkg::*;
#(
  parameter int unsigned LAST_EACH_SECTOR = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] first_sector,
  input  logic [15:0] sector_count,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        rd_start,
  output logic [31:0] rd_sector,
  input  logic        rd_busy,
  input  logic        rd_done,
  input  logic        rd_outen,
  input  logic [8:0]  rd_outaddr,
  input  logic [7:0]  rd_outbyte,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_last
);
  wstate_t           wstate;
  bank_t             wbank, rbank, ibank;
  logic [1:0]        full;
  logic [31:0]       next_sector;
  logic [15:0]       remaining, to_emit;
  logic [ADDR_W-1:0] ioff;
  logic              inflight, inflight_511;
  logic [1:0]        occ;
  logic [7:0]        e0_data, e1_data;
  logic              e0_511, e1_511;
  logic [7:0]        ram_rdata;
  logic              we, issue, pop, last_hs;

  // Issue a read only if the output buffer can absorb it even with no pop next cycle.
  always_comb begin
    pop     = (occ != 2'd0) && m_ready;
    last_hs = pop && e0_511;
    issue   = busy && full[ibank] &&
              (({1'b0, occ} + {2'b00, inflight} - {2'b00, pop}) <= 3'd1);
    we      = (wstate == W_WAIT) && rd_outen;
  end

  assign m_valid = (occ != 2'd0);
  assign m_data  = e0_data;
  assign m_last  = m_valid && e0_511 && ((LAST_EACH_SECTOR != 0) || (to_emit == 16'd1));

  sd_sector_dpram u_ram (
    .clk   (clk),
    .we    (we),
    .waddr ({wbank, rd_outaddr}),
    .wdata (rd_outbyte),
    .re    (issue),
    .raddr ({ibank, ioff}),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wstate       <= W_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      rd_start     <= 1'b0;
      rd_sector    <= '0;
      wbank        <= 1'b0;
      rbank        <= 1'b0;
      ibank        <= 1'b0;
      full         <= '0;
      next_sector  <= '0;
      remaining    <= '0;
      to_emit      <= '0;
      ioff         <= '0;
      inflight     <= 1'b0;
      inflight_511 <= 1'b0;
      occ          <= '0;
      e0_data      <= '0;
      e1_data      <= '0;
      e0_511       <= 1'b0;
      e1_511       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          next_sector <= first_sector;
          remaining   <= sector_count;
          to_emit     <= sector_count;
          if (sector_count == '0) done <= 1'b1;
          else                    busy <= 1'b1;
        end
      end else if (abort && wstate != W_DRAIN) begin
        // Flush the read side now; a read the host has accepted must still be drained.
        full     <= '0;
        occ      <= '0;
        inflight <= 1'b0;
        ioff     <= '0;
        ibank    <= 1'b0;
        rbank    <= 1'b0;
        wbank    <= 1'b0;
        rd_start <= 1'b0;
        if ((wstate == W_WAIT && !rd_done) || (wstate == W_ISSUE && rd_busy)) begin
          wstate <= W_DRAIN;
        end else begin
          wstate <= W_IDLE;
          busy   <= 1'b0;
          done   <= 1'b1;
        end
      end else begin
        case (wstate)
          W_IDLE: begin
            if (remaining != '0 && !full[wbank]) begin
              wstate    <= W_ISSUE;
              rd_start  <= 1'b1;
              rd_sector <= next_sector;
            end
          end
          W_ISSUE: begin
            if (rd_busy) begin
              rd_start <= 1'b0;
              wstate   <= W_WAIT;
            end
          end
          W_WAIT: begin
            if (rd_done) begin
              full[wbank] <= 1'b1;
              wbank       <= ~wbank;
              next_sector <= next_sector + 32'd1;
              remaining   <= remaining - 16'd1;
              wstate      <= W_IDLE;
            end
          end
          W_DRAIN: begin
            if (rd_done) begin
              wstate <= W_IDLE;
              busy   <= 1'b0;
              done   <= 1'b1;
            end
          end
          default: wstate <= W_IDLE;
        endcase

        if (issue) begin
          ioff <= ioff + 1'b1;
          if (ioff == '1) ibank <= ~ibank;
        end
        inflight     <= issue;
        inflight_511 <= issue && (ioff == '1);

        case ({inflight, pop})
          2'b10: begin
            if (occ == 2'd0) begin
              e0_data <= ram_rdata;
              e0_511  <= inflight_511;
            end else begin
              e1_data <= ram_rdata;
              e1_511  <= inflight_511;
            end
            occ <= occ + 2'd1;
          end
          2'b01: begin
            if (occ == 2'd2) begin
              e0_data <= e1_data;
              e0_511  <= e1_511;
            end
            occ <= occ - 2'd1;
          end
          2'b11: begin
            if (occ == 2'd1) begin
              e0_data <= ram_rdata;
              e0_511  <= inflight_511;
            end else begin
              e0_data <= e1_data;
              e0_511  <= e1_511;
              e1_data <= ram_rdata;
              e1_511  <= inflight_511;
            end
          end
          default: ;
        endcase

        if (last_hs) begin
          full[rbank] <= 1'b0;
          rbank       <= ~rbank;
          to_emit     <= to_emit - 16'd1;
          if (to_emit == 16'd1) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_sd_sector_streamer.sv
// Bench for sd_sector_streamer: behavioural SD host, random-ready consumer
// checked against a per-run expected byte list, plus abort/reset sequences.
module tb_sd_sector_streamer;
  localparam int unsigned LE = 0;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] first_sector = '0;
  logic [15:0] sector_count = '0;
  logic        abort = 1'b0;
  logic        busy, done, rd_start;
  logic [31:0] rd_sector;
  logic        rd_busy = 1'b0, rd_done = 1'b0, rd_outen = 1'b0;
  logic [8:0]  rd_outaddr = '0;
  logic [7:0]  rd_outbyte = '0;
  logic        m_valid, m_last;
  logic        m_ready = 1'b0;
  logic [7:0]  m_data;

  sd_sector_streamer #(.LAST_EACH_SECTOR(LE)) dut (
    .clk(clk), .rstn(rstn), .start(start), .first_sector(first_sector),
    .sector_count(sector_count), .abort(abort), .busy(busy), .done(done),
    .rd_start(rd_start), .rd_sector(rd_sector), .rd_busy(rd_busy),
    .rd_done(rd_done), .rd_outen(rd_outen), .rd_outaddr(rd_outaddr),
    .rd_outbyte(rd_outbyte), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       fin;
  } byte_t;

  typedef struct {
    logic [31:0] first;
    logic [15:0] count;
    int unsigned ready;
    logic        abort_w_start;
    int unsigned exp_starts;
    int unsigned exp_bytes;
  } vec_t;

  int unsigned errors = 0, checks = 0;
  byte_t       exp_q[$];
  int unsigned ready_pct = 100;
  int unsigned start_cnt = 0, consumed = 0, done_cnt = 0;
  logic [31:0] run_first = '0;
  int          h_phase = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input logic [31:0] s, input logic [8:0] a);
    logic [31:0] t;
    t = (s * 32'd29) ^ (32'(a) * 32'd7) ^ (32'(a) >> 3);
    return t[7:0];
  endfunction

  // Host writes bytes in a scrambled order so the address path matters.
  function automatic logic [8:0] perm(input int unsigned i);
    int unsigned t;
    t = (i * 5 + 3) % 512;
    return t[8:0];
  endfunction

  // Behavioural SD host.
  initial begin : host
    int unsigned h_wait, h_idx;
    logic [31:0] h_sector, exp_s;
    logic [8:0]  a;
    h_wait = 0; h_idx = 0; h_sector = '0;
    forever begin
      @(negedge clk);
      rd_done  = 1'b0;
      rd_outen = 1'b0;
      if (!rstn) begin
        h_phase = 0;
        rd_busy = 1'b0;
        continue;
      end
      case (h_phase)
        0: if (rd_start) begin
          exp_s = run_first + start_cnt;
          check("rd_sector", rd_sector, exp_s);
          if (start_cnt >= 2) check("bank_reuse", consumed >= (start_cnt - 1) * 512, 1);
          start_cnt++;
          h_sector = rd_sector;
          h_wait   = $urandom_range(3);
          h_phase  = 1;
        end
        1: begin
          check("rd_start_hold", {rd_start, rd_sector}, {1'b1, h_sector});
          if (h_wait == 0) begin
            rd_busy = 1'b1;
            h_idx   = 0;
            h_phase = 2;
          end else h_wait--;
        end
        2: if ($urandom_range(3) != 0) begin
          a          = perm(h_idx);
          rd_outen   = 1'b1;
          rd_outaddr = a;
          rd_outbyte = pat(h_sector, a);
          h_idx++;
          if (h_idx == 512) h_phase = 3;
        end
        3: begin
          rd_done = 1'b1;
          h_phase = 4;
        end
        default: begin
          rd_busy = 1'b0;
          h_phase = 0;
        end
      endcase
    end
  end

  // Consumer and stream checker.
  initial begin : consumer
    logic       prev_stall, prev_abort, prev_last, fin_pending;
    logic [7:0] prev_data;
    byte_t      e;
    prev_stall = 0; prev_abort = 0; prev_last = 0; fin_pending = 0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        m_ready = 1'b0;
        prev_stall = 0;
        fin_pending = 0;
        continue;
      end
      if (fin_pending) begin
        check("done_after_last", {done, busy}, 2'b10);
        fin_pending = 0;
      end
      if (prev_stall && !prev_abort)
        check("m_hold", {m_valid, m_data, m_last}, {1'b1, prev_data, prev_last});
      if (done) done_cnt++;
      m_ready = ($urandom_range(99) < ready_pct);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("extra_byte", m_valid, 0);
        else begin
          e = exp_q.pop_front();
          check("m_byte", {m_data, m_last}, {e.data, e.last});
          consumed++;
          if (e.fin) fin_pending = 1;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      prev_abort = abort;
    end
  end

  function automatic vec_t mk(input logic [31:0] f, input logic [15:0] c,
                              input int unsigned r, input logic ab);
    vec_t v;
    v.first = f; v.count = c; v.ready = r; v.abort_w_start = ab;
    v.exp_starts = c;
    v.exp_bytes  = 32'(c) * 512;
    return v;
  endfunction

  task automatic launch(input logic [31:0] f, input logic [15:0] c,
                        input int unsigned r, input logic ab);
    byte_t b;
    exp_q.delete();
    for (int unsigned s = 0; s < c; s++)
      for (int unsigned a = 0; a < 512; a++) begin
        b.data = pat(f + s, a[8:0]);
        b.last = (a == 511) && ((LE != 0) || (s == 32'(c) - 1));
        b.fin  = (a == 511) && (s == 32'(c) - 1);
        exp_q.push_back(b);
      end
    start_cnt = 0; consumed = 0; done_cnt = 0;
    run_first = f; ready_pct = r;
    @(posedge clk); #1;
    start = 1'b1; first_sector = f; sector_count = c; abort = ab;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned n;
    launch(v.first, v.count, v.ready, v.abort_w_start);
    if (v.count == 0) begin
      check("zero_done", {done, busy}, 2'b10);
      @(posedge clk); #1;
      check("zero_idle", {done, busy}, 2'b00);
    end else check("busy_rise", {done, busy}, 2'b01);
    n = 0;
    while (done_cnt == 0 && n < 32'(v.count) * 3000 + 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("run_timeout", done_cnt != 0, 1);
    repeat (4) @(posedge clk);
    #1;
    check("starts", start_cnt, v.exp_starts);
    check("bytes", consumed, v.exp_bytes);
    check("left", exp_q.size(), 0);
    check("done_cnt", done_cnt, 1);
    check("idle", {busy, m_valid, rd_start}, 0);
  endtask

  task automatic abort_seq();
    int unsigned n, starts_at;
    logic saw, bad_busy, bad_valid;
    launch(32'd500, 16'd4, 100, 1'b0);
    n = 0;
    while (!(start_cnt == 2 && h_phase == 2) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_reach", start_cnt == 2 && h_phase == 2, 1);
    repeat (10) @(posedge clk);
    #1;
    check("abort_pre_valid", m_valid, 1);
    starts_at = start_cnt;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    check("abort_mvalid", m_valid, 0);
    check("abort_busy_hold", busy, 1);
    saw = 0; bad_busy = 0; bad_valid = 0; n = 0;
    while (!saw && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (rd_done) begin
        saw = 1;
        check("abort_done", {done, busy}, 2'b10);
      end else begin
        if (!busy) bad_busy = 1;
        if (m_valid) bad_valid = 1;
      end
    end
    check("abort_rd_done_seen", saw, 1);
    check("abort_busy_until_rd_done", bad_busy, 0);
    check("abort_valid_low", bad_valid, 0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_rdstart", start_cnt, starts_at);
    check("abort_done_cnt", done_cnt, 1);
  endtask

  task automatic reset_seq();
    int unsigned n;
    launch(32'h1234, 16'd2, 100, 1'b0);
    n = 0;
    while (!m_valid && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_pre_valid", m_valid, 1);
    #2 rstn = 1'b0;
    exp_q.delete();
    #1;
    check("rst_outputs", {busy, done, rd_start, rd_sector, m_valid, m_data, m_last}, 0);
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
  endtask

  vec_t vecs[9];

  initial begin : main
    vecs[0] = mk(32'd100, 16'd1, 100, 1'b0);
    vecs[1] = mk(32'd7, 16'd3, 50, 1'b0);
    vecs[2] = mk(32'd42, 16'd0, 100, 1'b0);
    vecs[3] = mk(32'hFFFF_FFFF, 16'd2, 70, 1'b0);
    vecs[4] = mk(32'd3, 16'd1, 80, 1'b1);
    for (int unsigned i = 5; i < 9; i++)
      vecs[i] = mk($urandom, 16'($urandom_range(1, 3)), $urandom_range(30, 100), 1'b0);

    @(posedge clk); #1;
    check("reset_state", {busy, done, rd_start, rd_sector, m_valid, m_data, m_last}, 0);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;

    for (int unsigned i = 0; i < 9; i++) run_vec(vecs[i]);
    abort_seq();
    run_vec(mk(32'd900, 16'd2, 60, 1'b0));
    reset_seq();
    run_vec(mk(32'd55, 16'd1, 90, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sd_sector_streamer.md
Name: sd_sector_streamer

Overview:
- Sits between the SD sector-read host and downstream byte consumers.
- Fetches a run of consecutive sectors through the host's rstart/rsector/rbusy/rdone handshake.
- Captures the host's outen/outaddr/outbyte writes into a two-bank 512-byte ping-pong buffer.
- Replays each buffered sector as a valid/ready byte stream, so one sector drains while the next loads.

Parameters:
LAST_EACH_SECTOR, 0, 1: m_last on byte 511 of every sector; 0: only on byte 511 of the final sector.

Ports:
clk  in  1  clock; same clock as the SD host
rstn  in  1  reset, asynchronous, active-low
start  in  1  one-cycle request to begin a run; ignored while busy=1
first_sector  in  32  first sector index, sampled when start is accepted
sector_count  in  16  number of sectors, sampled when start is accepted
abort  in  1  one-cycle request to stop the run
busy  out  1  run in progress
done  out  1  one-cycle pulse when a run completes or finishes aborting
rd_start  out  1  read request to the SD host
rd_sector  out  32  sector index presented with rd_start
rd_busy  in  1  SD host busy; low only when it can accept a read
rd_done  in  1  SD host sector-complete pulse
rd_outen  in  1  SD host byte strobe
rd_outaddr  in  9  byte offset within the sector
rd_outbyte  in  8  byte data
m_valid  out  1  stream byte valid
m_ready  in  1  consumer ready
m_data  out  8  stream byte
m_last  out  1  last-byte marker

Behaviour:
- Reset values: busy, done, rd_start, m_valid, m_last = 0; rd_sector = 0; m_data = 0. Both banks empty; wbank = rbank = 0; all counters 0.
- Accepting start (busy=0, start=1):
  - Latch next_sector = first_sector, remaining = sector_count, to_emit = sector_count.
  - Set busy=1 on the next cycle.
  - If sector_count = 0: done pulses on the next cycle, busy stays 0, no rd_start is issued.
- Write FSM states: W_IDLE, W_ISSUE, W_WAIT, W_DRAIN.
  - W_IDLE → W_ISSUE when busy, remaining ≠ 0, bank[wbank] empty and no abort.
  - W_ISSUE: drive rd_start=1 and rd_sector=next_sector. rd_start stays high until rd_busy=1 is sampled; then → W_WAIT with rd_start=0 that same cycle.
  - W_WAIT:
    - Each rd_outen writes rd_outbyte to ram[{wbank, rd_outaddr}].
    - On rd_done: mark bank[wbank] full, toggle wbank, next_sector += 1 (32-bit wrap), remaining -= 1, then → W_IDLE.
  - W_DRAIN: entered on abort while in W_WAIT. rd_outen is ignored (no RAM writes). On rd_done → W_IDLE and the abort completes.
- rd_outen or rd_done outside W_WAIT/W_DRAIN is ignored.
- Read side:
  - RAM read is synchronous, 1-cycle latency.
  - A 2-entry output buffer sustains 1 byte/cycle while m_ready=1.
  - First byte of a newly full bank is on m_valid no later than 3 cycles after the full flag sets.
  - Bytes leave in address order 0..511.
  - Handshake occurs when m_valid & m_ready. m_data and m_last are held stable while m_valid & ~m_ready. m_valid never drops without a handshake, except on abort.
  - m_last = 1 on byte 511 when LAST_EACH_SECTOR=1, or on byte 511 of the final sector.
  - Handshake of byte 511: clear bank[rbank] full (a write may reuse it from the next cycle), toggle rbank, to_emit -= 1.
- Completion: when to_emit reaches 0, busy falls and done pulses on the cycle after the last handshake.
- Abort:
  - m_valid drops on the next cycle; the output buffer and both full flags clear; no further rd_start.
  - Abort in W_ISSUE before rd_busy=1 drops rd_start and completes immediately.
  - Abort in W_WAIT waits in W_DRAIN for rd_done.
  - On completion: done pulses, busy falls.
  - start and abort in the same cycle while idle: start wins, abort ignored.
- The SD host holds rd_busy=1 during card initialisation; W_ISSUE simply waits.
- Reset mid-run returns all state to reset values asynchronously. The SD host is reset by the same rstn.

Decomposition:
- Package sd_stream_pkg:
  - SECTOR_BYTES=512, ADDR_W=9.
  - Write-state encodings (W_IDLE, W_ISSUE, W_WAIT, W_DRAIN).
  - Bank index typedef.
- Sub-module sd_sector_dpram: 1024x8, one synchronous write port, one synchronous read port, no reset on array contents.

Test Plan:
- first_sector=100, count=1, m_ready=1 → rd_sector=100 held until rd_busy=1; 512 bytes match the model pattern; m_last only on byte 511; done pulses 1 cycle after that handshake.
- first_sector=7, count=3, m_ready 50% random → rd_sectors 7, 8, 9 in order; third rd_start waits until sector 7 is fully drained; no byte lost or duplicated; with LAST_EACH_SECTOR=0, m_last only on sector 9 byte 511.
- count=0 → done pulse 1 cycle after start; rd_start never asserted; busy stays 0.
- first_sector=0xFFFFFFFF, count=2 → rd_sector FFFFFFFF then 00000000.
- abort mid-W_WAIT → no further rd_start; busy stays high until rd_done, then done pulses; m_valid=0 from the cycle after abort.
- rstn low mid-stream with m_valid=1 → all outputs at reset values immediately; a new start afterwards runs cleanly.
